l1a_ring_sched: RTL

Schedules ring-buffer readout for the DCFEB event path. Captures each accepted L1A together with the ring sample address it points at, and queues these entries in a small FIFO. Presents the oldest entry to the ring-transfer state machine, which consumes it through its LD_ADDR / NXT_L1A pulses. Sits between the trigger input logic and the ring-transfer FSM, and drives that FSM's L1A_BUF_MT input.

---
 rtl/dcfeb_ring_pkg.sv | 19 +
 rtl/l1a_ring_sched_if.sv | 32 +++
 rtl/l1a_sched_fifo.sv | 85 ++++++++
 rtl/l1a_ring_sched.sv | 118 +++++++++++
 4 files changed

// File: rtl/dcfeb_ring_pkg.sv
// Shared definitions for the DCFEB ring-readout path: transfer handshake
// state encoding, default widths and the TMR majority voter.
package dcfeb_ring_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    BUSY = 2'd2
  } l1a_state_e;

  localparam int AW_DEF = 9;
  localparam int NW_DEF = 12;

  // Bitwise 2-of-3 vote; callers loop over the bits of wider values.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/l1a_ring_sched_if.sv
// Bus between the trigger/transfer logic and l1a_ring_sched.
// master: trigger input logic + ring-transfer FSM; slave: the scheduler.
interface l1a_ring_sched_if
  import dcfeb_ring_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int NW = NW_DEF
);
  logic          L1A;
  logic [AW-1:0] RING_WADDR;
  logic [AW-1:0] L1A_DLY;
  logic          LD_ADDR;
  logic          NXT_L1A;
  logic          L1A_BUF_MT;
  logic          L1A_BUF_FULL;
  logic [AW-1:0] RD_ADDR;
  logic [NW-1:0] L1A_NUM;
  logic [NW-1:0] L1A_CNT;
  logic          OVFL;
  logic          PROT_ERR;

  modport master (
    output L1A, RING_WADDR, L1A_DLY, LD_ADDR, NXT_L1A,
    input  L1A_BUF_MT, L1A_BUF_FULL, RD_ADDR, L1A_NUM, L1A_CNT, OVFL, PROT_ERR
  );

  modport slave (
    input  L1A, RING_WADDR, L1A_DLY, LD_ADDR, NXT_L1A,
    output L1A_BUF_MT, L1A_BUF_FULL, RD_ADDR, L1A_NUM, L1A_CNT, OVFL, PROT_ERR
  );

endinterface

// File: rtl/l1a_sched_fifo.sv
// L1A entry storage: DEPTH x {ring start address, L1A number} circular
// buffer with write/read pointers and a registered head entry.
// Optional macro L1A_SCHED_TMR_EN triplicates the pointers (storage and
// head register stay single).
module l1a_sched_fifo
  import dcfeb_ring_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [NW-1:0] wnum_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [NW-1:0] l1a_num_o
);

  localparam int LG = $clog2(DEPTH);
`ifdef L1A_SCHED_TMR_EN
  localparam int NR = 3;
`else
  localparam int NR = 1;
`endif

  logic [LG-1:0]    wr_q [NR];
  logic [LG-1:0]    rd_q [NR];
  logic [LG-1:0]    wr_v, rd_v, wr_d, rd_d;
  logic [AW+NW-1:0] mem_q [DEPTH];
  logic [AW+NW-1:0] head_q, head_d, wdata;

  assign wdata = {waddr_i, wnum_i};

  // Resolve the pointer copies into one working value
  always_comb begin
    wr_v = wr_q[0];
    rd_v = rd_q[0];
`ifdef L1A_SCHED_TMR_EN
    for (int b = 0; b < LG; b++) begin
      wr_v[b] = maj3(wr_q[0][b], wr_q[1][b], wr_q[2][b]);
      rd_v[b] = maj3(rd_q[0][b], rd_q[1][b], rd_q[2][b]);
    end
`endif
  end

  // Next pointers and head; a push landing in the next read slot bypasses storage
  always_comb begin
    wr_d   = push_i ? wr_v + LG'(1) : wr_v;
    rd_d   = pop_i  ? rd_v + LG'(1) : rd_v;
    head_d = (push_i && (wr_v == rd_d)) ? wdata : mem_q[rd_d];
  end

  // Every pointer copy reloads from the voted next value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NR; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NR; i++) begin
        wr_q[i] <= wr_d;
        rd_q[i] <= rd_d;
      end
    end
  end

  // Entry storage; contents are meaningless until written
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_v] <= wdata;
  end

  // Registered head entry presented to the transfer FSM
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) head_q <= '0;
    else        head_q <= head_d;
  end

  assign rd_addr_o = head_q[AW+NW-1:NW];
  assign l1a_num_o = head_q[NW-1:0];

endmodule

// File: rtl/l1a_ring_sched.sv
// L1A ring-readout scheduler: captures accepted L1As with their ring start
// address, queues them, and hands the oldest to the ring-transfer FSM via
// the LD_ADDR / NXT_L1A handshake.
// Optional macro L1A_SCHED_TMR_EN triplicates occupancy, state, L1A counter
// and flags; outputs are the voted values.
module l1a_ring_sched
  import dcfeb_ring_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = AW_DEF,
  parameter int NW    = NW_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  l1a_ring_sched_if.slave bus
);

  localparam int LG = $clog2(DEPTH);
  localparam logic [LG:0] FULL_CNT = (LG+1)'(DEPTH);
`ifdef L1A_SCHED_TMR_EN
  localparam int NR = 3;
`else
  localparam int NR = 1;
`endif

  typedef struct packed {
    logic          prot;
    logic          ovfl;
    logic          full;
    logic          mt;
    logic [NW-1:0] num;
    l1a_state_e    st;
    logic [LG:0]   cnt;
  } ctl_t;

  localparam ctl_t CTL_RST = '{prot: 1'b0, ovfl: 1'b0, full: 1'b0, mt: 1'b1,
                               num: '0, st: IDLE, cnt: '0};

  ctl_t          ctl_q [NR];
  ctl_t          ctl_v, ctl_d;
  logic          full_now, pop, push;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] rd_addr;
  logic [NW-1:0] l1a_num;

  // Ring sample the trigger refers to, modulo the ring size
  assign start_addr = bus.RING_WADDR - bus.L1A_DLY;

  // Resolve the control copies into one working value
  always_comb begin
    ctl_v = ctl_q[0];
`ifdef L1A_SCHED_TMR_EN
    for (int b = 0; b < $bits(ctl_t); b++) begin
      ctl_v[b] = maj3(ctl_q[0][b], ctl_q[1][b], ctl_q[2][b]);
    end
`endif
  end

  // Handshake FSM, occupancy, L1A numbering and sticky flags
  always_comb begin
    ctl_d    = ctl_v;
    full_now = (ctl_v.cnt == FULL_CNT);
    pop      = bus.NXT_L1A && (ctl_v.st == BUSY);
    push     = bus.L1A && (!full_now || pop);

    if (push && !pop)      ctl_d.cnt = ctl_v.cnt + (LG+1)'(1);
    else if (pop && !push) ctl_d.cnt = ctl_v.cnt - (LG+1)'(1);

    // Numbering follows every trigger, kept or dropped
    if (bus.L1A)          ctl_d.num  = ctl_v.num + NW'(1);
    if (bus.L1A && !push) ctl_d.ovfl = 1'b1;
    if ((bus.LD_ADDR && (ctl_v.st != PEND)) || (bus.NXT_L1A && (ctl_v.st != BUSY)))
      ctl_d.prot = 1'b1;

    case (ctl_v.st)
      IDLE:    if (ctl_d.cnt != '0) ctl_d.st = PEND;
      PEND:    if (bus.LD_ADDR)     ctl_d.st = BUSY;
      BUSY:    if (pop)             ctl_d.st = (ctl_d.cnt != '0) ? PEND : IDLE;
      default: ctl_d.st = IDLE;
    endcase

    ctl_d.mt   = (ctl_d.cnt == '0);
    ctl_d.full = (ctl_d.cnt == FULL_CNT);
  end

  // Control state register; all copies reload from the voted next value
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NR; i++) ctl_q[i] <= CTL_RST;
    end else begin
      for (int i = 0; i < NR; i++) ctl_q[i] <= ctl_d;
    end
  end

  l1a_sched_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NW    (NW)
  ) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push_i    (push),
    .pop_i     (pop),
    .waddr_i   (start_addr),
    .wnum_i    (ctl_v.num),
    .rd_addr_o (rd_addr),
    .l1a_num_o (l1a_num)
  );

  assign bus.L1A_BUF_MT   = ctl_v.mt;
  assign bus.L1A_BUF_FULL = ctl_v.full;
  assign bus.L1A_CNT      = ctl_v.num;
  assign bus.OVFL         = ctl_v.ovfl;
  assign bus.PROT_ERR     = ctl_v.prot;
  assign bus.RD_ADDR      = rd_addr;
  assign bus.L1A_NUM      = l1a_num;

endmodule
